// File: rtl/hot_mig_dispatch.sv
// Hot-page migration dispatcher: scans a latched top-K snapshot and hands
// qualifying addresses to per-channel one-deep output slots in entry order.
module hot_mig_dispatch #(
  parameter int ADDR_SIZE    = 22,
  parameter int CNT_SIZE     = 18,
  parameter int NUM_ENTRY    = 25,
  parameter int INDEX_SIZE   = 5,
  parameter int NUM_CHAN     = 2,
  parameter int CHAN_SEL_LSB = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          snap_valid,
  output logic                          snap_ready,
  input  logic [NUM_ENTRY*ADDR_SIZE-1:0] snap_addr,
  input  logic [NUM_ENTRY*CNT_SIZE-1:0]  snap_cnt,
  input  logic [CNT_SIZE-1:0]            cnt_threshold,
  input  logic                          flush,
  output logic [NUM_CHAN-1:0]            mig_addr_en,
  output logic [NUM_CHAN*ADDR_SIZE-1:0]  mig_addr,
  input  logic [NUM_CHAN-1:0]            mig_addr_ready,
  output logic                          mig_done,
  output logic [INDEX_SIZE:0]            mig_issued
);

  localparam int CHAN_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam logic [INDEX_SIZE-1:0] LAST_IDX   = INDEX_SIZE'(NUM_ENTRY - 1);
  localparam logic [ADDR_SIZE-1:0]  EMPTY_ADDR = {ADDR_SIZE{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic [INDEX_SIZE-1:0]  ptr_r, ptr_s;
  logic [ADDR_SIZE-1:0]   lat_addr_r [NUM_ENTRY];
  logic [CNT_SIZE-1:0]    lat_cnt_r  [NUM_ENTRY];
  logic [CNT_SIZE-1:0]    lat_thr_r;
  logic [NUM_CHAN-1:0]    en_r;
  logic [ADDR_SIZE-1:0]   slot_r [NUM_CHAN];
  logic                   done_r, done_s;
  logic [INDEX_SIZE:0]    issued_r;

  logic [ADDR_SIZE-1:0]   cur_addr_s;
  logic [CNT_SIZE-1:0]    cur_cnt_s;
  logic                   qual_s;
  logic [CHAN_W-1:0]      ch_s;
  logic                   slot_free_s;
  logic [NUM_CHAN-1:0]    hs_s;
  logic [NUM_CHAN-1:0]    load_s;
  logic [INDEX_SIZE:0]    hs_cnt_s;
  logic                   accept_s;
  logic                   advance_s;

  // Decode the entry under the pointer and the handshakes of this cycle.
  always_comb begin
    cur_addr_s = lat_addr_r[ptr_r];
    cur_cnt_s  = lat_cnt_r[ptr_r];
    qual_s     = (cur_addr_s != EMPTY_ADDR) && (cur_cnt_s >= lat_thr_r);
    if (NUM_CHAN > 1) begin
      ch_s = cur_addr_s[CHAN_SEL_LSB +: CHAN_W];
    end else begin
      ch_s = {CHAN_W{1'b0}};
    end
    // A full slot that hands off this cycle can take the next entry at once.
    slot_free_s = !en_r[ch_s] || mig_addr_ready[ch_s];
    hs_s        = en_r & mig_addr_ready;
    hs_cnt_s    = {(INDEX_SIZE+1){1'b0}};
    for (int c = 0; c < NUM_CHAN; c++) begin
      hs_cnt_s = hs_cnt_s + {{INDEX_SIZE{1'b0}}, hs_s[c]};
    end
  end

  // Next-state logic: accept, scan/skip/stall, drain, with flush overriding all.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    load_s    = {NUM_CHAN{1'b0}};
    accept_s  = 1'b0;
    advance_s = 1'b0;
    done_s    = 1'b0;
    if (flush) begin
      state_s = IDLE;
      ptr_s   = {INDEX_SIZE{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (snap_valid) begin
            accept_s = 1'b1;
            ptr_s    = {INDEX_SIZE{1'b0}};
            state_s  = SCAN;
          end else begin
            state_s = IDLE;
          end
        end
        SCAN: begin
          if (!qual_s) begin
            advance_s = 1'b1;
          end else if (slot_free_s) begin
            advance_s      = 1'b1;
            load_s[ch_s]   = 1'b1;
          end else begin
            advance_s = 1'b0;
          end
          if (advance_s) begin
            if (ptr_r == LAST_IDX) begin
              state_s = DRAIN;
            end else begin
              ptr_s = ptr_r + INDEX_SIZE'(1);
            end
          end else begin
            ptr_s = ptr_r;
          end
        end
        DRAIN: begin
          if ((en_r & ~mig_addr_ready) == {NUM_CHAN{1'b0}}) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = DRAIN;
          end
        end
        default: begin
          state_s = IDLE;
          ptr_s   = {INDEX_SIZE{1'b0}};
        end
      endcase
    end
  end

  // Control state, scan pointer, completion pulse and issued counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      ptr_r    <= {INDEX_SIZE{1'b0}};
      done_r   <= 1'b0;
      issued_r <= {(INDEX_SIZE+1){1'b0}};
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      done_r  <= done_s;
      if (accept_s) begin
        issued_r <= {(INDEX_SIZE+1){1'b0}};
      end else if (!flush) begin
        issued_r <= issued_r + hs_cnt_s;
      end
    end
  end

  // Per-channel output slots; an empty slot always shows all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      en_r <= {NUM_CHAN{1'b0}};
      for (int c = 0; c < NUM_CHAN; c++) slot_r[c] <= EMPTY_ADDR;
    end else begin
      for (int c = 0; c < NUM_CHAN; c++) begin
        if (load_s[c]) begin
          en_r[c]   <= 1'b1;
          slot_r[c] <= cur_addr_s;
        end else if (hs_s[c]) begin
          en_r[c]   <= 1'b0;
          slot_r[c] <= EMPTY_ADDR;
        end
      end
    end
  end

  // Snapshot capture; contents only change on an accepted offer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_thr_r <= {CNT_SIZE{1'b0}};
      for (int i = 0; i < NUM_ENTRY; i++) begin
        lat_addr_r[i] <= EMPTY_ADDR;
        lat_cnt_r[i]  <= {CNT_SIZE{1'b0}};
      end
    end else if (accept_s) begin
      lat_thr_r <= cnt_threshold;
      for (int i = 0; i < NUM_ENTRY; i++) begin
        lat_addr_r[i] <= snap_addr[i*ADDR_SIZE +: ADDR_SIZE];
        lat_cnt_r[i]  <= snap_cnt[i*CNT_SIZE +: CNT_SIZE];
      end
    end
  end

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_out
    assign mig_addr[g*ADDR_SIZE +: ADDR_SIZE] = slot_r[g];
  end

  assign snap_ready  = (state_r == IDLE);
  assign mig_addr_en = en_r;
  assign mig_done    = done_r;
  assign mig_issued  = issued_r;

endmodule

// File: tb/tb_hot_mig_dispatch.sv
// Bench for hot_mig_dispatch: directed scenarios plus random snapshots checked
// against per-channel expected-address queues built from the selection rules.
module tb_hot_mig_dispatch;

  localparam int AW = 22;
  localparam int CW = 18;
  localparam int NE = 4;
  localparam int IW = 2;
  localparam int NC = 2;
  localparam logic [AW-1:0] ONES = {AW{1'b1}};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              snap_valid = 1'b0;
  logic              snap_ready;
  logic [NE*AW-1:0]  snap_addr = {(NE*AW){1'b1}};
  logic [NE*CW-1:0]  snap_cnt = {(NE*CW){1'b0}};
  logic [CW-1:0]     cnt_threshold = {CW{1'b0}};
  logic              flush = 1'b0;
  logic [NC-1:0]     mig_addr_en;
  logic [NC*AW-1:0]  mig_addr;
  logic [NC-1:0]     mig_addr_ready = 2'b11;
  logic              mig_done;
  logic [IW:0]       mig_issued;

  always #5 clk = ~clk;

  hot_mig_dispatch #(
    .ADDR_SIZE(AW), .CNT_SIZE(CW), .NUM_ENTRY(NE), .INDEX_SIZE(IW),
    .NUM_CHAN(NC), .CHAN_SEL_LSB(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .snap_valid(snap_valid), .snap_ready(snap_ready),
    .snap_addr(snap_addr), .snap_cnt(snap_cnt), .cnt_threshold(cnt_threshold),
    .flush(flush), .mig_addr_en(mig_addr_en), .mig_addr(mig_addr),
    .mig_addr_ready(mig_addr_ready), .mig_done(mig_done), .mig_issued(mig_issued)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [AW-1:0] q0[$];
  logic [AW-1:0] q1[$];
  int hs_total = 0;
  int exp_total = 0;
  bit mon_on = 1'b0;
  logic [NC-1:0] prev_en = 2'b00;
  logic [NC-1:0] prev_hs = 2'b00;
  logic [AW-1:0] prev_addr [NC];
  logic [AW-1:0] a_m;
  logic [AW-1:0] exp_m;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // Output observer: ordering against the model queues, hold-stability, idle value.
  task automatic monitor();
    if (mon_on) begin
      chk("issued_running", 32'(mig_issued), 32'(hs_total));
      for (int c = 0; c < NC; c++) begin
        a_m = mig_addr[c*AW +: AW];
        if (mig_addr_en[c]) begin
          if (prev_en[c] && !prev_hs[c]) chk("hold_stable", 32'(a_m), 32'(prev_addr[c]));
          if (mig_addr_ready[c]) begin
            if (c == 0 && q0.size() > 0) exp_m = q0.pop_front();
            else if (c == 1 && q1.size() > 0) exp_m = q1.pop_front();
            else exp_m = ONES;
            chk(c == 0 ? "emit_ch0" : "emit_ch1", 32'(a_m), 32'(exp_m));
            hs_total++;
          end
        end else begin
          chk("idle_all_ones", 32'(a_m), 32'(ONES));
        end
        prev_en[c]   = mig_addr_en[c];
        prev_hs[c]   = mig_addr_en[c] & mig_addr_ready[c];
        prev_addr[c] = a_m;
      end
    end else begin
      prev_en = 2'b00;
      prev_hs = 2'b00;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [NE*AW-1:0] a, input logic [NE*CW-1:0] c,
                      input logic [CW-1:0] t, input int hold);
    logic [AW-1:0] ai;
    logic [CW-1:0] ci;
    for (int n = 0; n < 50 && !snap_ready; n++) step();
    chk("ready_before_send", 32'(snap_ready), 32'd1);
    snap_addr = a; snap_cnt = c; cnt_threshold = t; snap_valid = 1'b1;
    step();
    hs_total = 0;
    exp_total = 0;
    for (int i = 0; i < NE; i++) begin
      ai = a[i*AW +: AW];
      ci = c[i*CW +: CW];
      if (ai != ONES && ci >= t) begin
        if (ai[0]) q1.push_back(ai); else q0.push_back(ai);
        exp_total++;
      end
    end
    chk("busy_after_accept", 32'(snap_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      snap_addr = ~a; snap_cnt = ~c; cnt_threshold = {CW{1'b0}};
      step();
    end
    snap_valid = 1'b0;
  endtask

  // mode 0: consumers always ready; mode 1: random per-cycle readiness.
  task automatic run_until_done(input int mode, input int exp_lat);
    int lat;
    bit seen;
    lat = 0; seen = 1'b0;
    for (int n = 1; n <= 200 && !seen; n++) begin
      mig_addr_ready = (mode == 0) ? 2'b11 : 2'($urandom_range(0, 3));
      step();
      if (mig_done) begin seen = 1'b1; lat = n; end
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (exp_lat > 0) chk("done_latency", 32'(lat), 32'(exp_lat));
    chk("issued_final", 32'(mig_issued), 32'(exp_total));
    chk("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
    chk("ready_after_done", 32'(snap_ready), 32'd1);
    mig_addr_ready = 2'b11;
    step();
    chk("done_single_pulse", 32'(mig_done), 32'd0);
    chk("issued_holds", 32'(mig_issued), 32'(exp_total));
  endtask

  logic [NE*AW-1:0] base_a, stall_a, empty_a, flush_a, rnd_a;
  logic [NE*CW-1:0] base_c, rnd_c;

  initial begin
    base_a  = {22'h13, 22'h12, 22'h11, 22'h10};
    base_c  = {18'd6, 18'd7, 18'd8, 18'd9};
    stall_a = {ONES, 22'h24, 22'h22, 22'h20};
    empty_a = {ONES, ONES, ONES, ONES};
    flush_a = {22'h26, 22'h24, 22'h22, 22'h20};

    step(); step();
    rst_n = 1'b1;
    chk("rst_snap_ready", 32'(snap_ready), 32'd1);
    chk("rst_en", 32'(mig_addr_en), 32'd0);
    chk("rst_addr0", 32'(mig_addr[AW-1:0]), 32'(ONES));
    chk("rst_addr1", 32'(mig_addr[2*AW-1:AW]), 32'(ONES));
    chk("rst_done", 32'(mig_done), 32'd0);
    chk("rst_issued", 32'(mig_issued), 32'd0);
    mon_on = 1'b1;

    // All entries qualify, one per cycle, alternating channels.
    send(base_a, base_c, 18'd5, 0);
    run_until_done(0, 5);

    // Threshold filters out the colder half.
    send(base_a, base_c, 18'd8, 0);
    run_until_done(0, 5);

    // Channel 0 back-pressure stalls the scan on entry 1.
    send(stall_a, {18'd1, 18'd2, 18'd3, 18'd4}, 18'd0, 0);
    mig_addr_ready = 2'b10;
    repeat (5) step();
    chk("stall_en", 32'(mig_addr_en), 32'd1);
    chk("stall_addr0", 32'(mig_addr[AW-1:0]), 32'h20);
    chk("stall_issued", 32'(mig_issued), 32'd0);
    run_until_done(0, 0);

    // Nothing qualifies: full scan, one drain cycle, done with zero issued.
    send(empty_a, base_c, 18'd0, 0);
    run_until_done(0, 5);

    // Flush while stalled aborts without a completion pulse.
    send(flush_a, base_c, 18'd0, 0);
    mig_addr_ready = 2'b00;
    repeat (3) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    q0.delete(); q1.delete();
    chk("flush_en", 32'(mig_addr_en), 32'd0);
    chk("flush_idle", 32'(snap_ready), 32'd1);
    chk("flush_no_done", 32'(mig_done), 32'd0);
    chk("flush_issued_hold", 32'(mig_issued), 32'd0);
    send(base_a, base_c, 18'd5, 0);
    run_until_done(0, 5);

    // A second offer during SCAN must be ignored.
    mig_addr_ready = 2'b11;
    send(base_a, base_c, 18'd5, 2);
    run_until_done(0, 3);

    // Reset mid-scan drops pending work with no done.
    send(stall_a, base_c, 18'd0, 0);
    mig_addr_ready = 2'b00;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    q0.delete(); q1.delete();
    hs_total = 0;
    chk("midrst_en", 32'(mig_addr_en), 32'd0);
    chk("midrst_done", 32'(mig_done), 32'd0);
    chk("midrst_issued", 32'(mig_issued), 32'd0);
    chk("midrst_ready", 32'(snap_ready), 32'd1);
    mig_addr_ready = 2'b11;
    step();
    chk("midrst_no_done", 32'(mig_done), 32'd0);

    // Random snapshots, thresholds and consumer readiness.
    for (int r = 0; r < 30; r++) begin
      int mode;
      for (int i = 0; i < NE; i++) begin
        rnd_a[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? ONES : AW'($urandom);
        rnd_c[i*CW +: CW] = CW'($urandom_range(0, 15));
      end
      mode = int'($urandom_range(0, 1));
      send(rnd_a, rnd_c, CW'($urandom_range(0, 15)), 0);
      run_until_done(mode, (mode == 0) ? 5 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
